// File: rtl/csr_file_m.sv
// Machine-mode CSR register file: combinational read port, single write/trap
// port, mret handling, interrupt pending generation, 64-bit counters and the
// trap target (direct or vectored) consumed by the fetch unit.
module csr_file_m #(
    parameter int              XLEN        = 32,
    parameter int              HART_ID     = 0,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter int              NUM_HPM     = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [11:0]                             r_addr,
    output logic [XLEN-1:0]                         r_rdata,
    output logic                                    r_ro,
    output logic                                    r_exception,
    output logic [XLEN-1:0]                         mtvec,
    output logic [XLEN-1:0]                         mepc,
    input  logic [11:0]                             w_addr,
    input  logic [XLEN-1:0]                         w_data,
    input  logic [XLEN-1:0]                         w_pc,
    input  logic [XLEN-1:0]                         w_cause,
    input  logic                                    w_trap,
    input  logic                                    w_valid,
    input  logic                                    mret,
    input  logic                                    instret,
    input  logic [((NUM_HPM == 0) ? 1 : NUM_HPM)-1:0] hpm_event,
    input  logic [2:0]                              irq_m,
    output logic                                    irq_pending,
    output logic [XLEN-1:0]                         trap_target
);
    localparam int HPM_N = (NUM_HPM == 0) ? 1 : NUM_HPM;
    localparam logic [1:0] MXL = (XLEN == 32) ? 2'b01 : 2'b10;
    localparam logic [XLEN-1:0] MISA = {MXL, {(XLEN-11){1'b0}}, 9'h100};

    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
    logic            r_mstatus_mie, r_mstatus_mpie, r_irq;
    logic [2:0]      r_mie_en;     // {MEIE, MTIE, MSIE}
    logic [63:0]     r_mcycle, r_minstret;
    logic [HPM_N-1:0][63:0] r_hpm;

    logic            w_we, w_trap_en, w_mret_en;
    logic [63:0]     w_wd64;
    logic [XLEN-1:0] w_mstatus, w_mie_csr, w_mip_csr, w_base, w_rdata;
    logic [63:0]     w_cnt;
    logic            w_cnt_ok, w_rexc, w_unused;

    assign w_trap_en = w_valid & w_trap;
    assign w_we      = w_valid & ~w_trap;
    assign w_mret_en = mret & ~w_trap_en;   // a coincident trap swallows mret
    assign w_wd64    = 64'(w_data);
    assign w_unused  = &{1'b0, w_pc[1:0]};

    assign mtvec       = r_mtvec;
    assign mepc        = r_mepc;
    assign irq_pending = r_irq;
    assign r_ro        = (r_addr[11:10] == 2'b11);
    assign r_rdata     = w_rdata;
    assign r_exception = w_rexc;

    // trap target: vectored only for interrupts when mtvec mode is 1
    assign w_base      = {r_mtvec[XLEN-1:2], 2'b00};
    assign trap_target = (r_mtvec[0] && w_cause[XLEN-1])
                         ? w_base + XLEN'({w_cause[4:0], 2'b00}) : w_base;

    // counter next value; a write to either half replaces that cycle's increment
    function automatic logic [63:0] f_cnt_next(input logic [63:0] cur, input logic inc,
                                               input logic hit_lo, input logic hit_hi,
                                               input logic [63:0] wd);
        logic [63:0] nxt;
        nxt = cur + {63'd0, inc};
        if (hit_lo)      nxt = (XLEN == 64) ? wd : {cur[63:32], wd[31:0]};
        else if (hit_hi) nxt = {wd[31:0], cur[31:0]};
        return nxt;
    endfunction

    // CSR views assembled from the individual state bits
    always_comb begin
        w_mstatus     = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]  = r_mstatus_mpie;
        w_mstatus[3]  = r_mstatus_mie;
        w_mie_csr     = '0;
        w_mie_csr[3]  = r_mie_en[0];
        w_mie_csr[7]  = r_mie_en[1];
        w_mie_csr[11] = r_mie_en[2];
        w_mip_csr     = '0;
        w_mip_csr[3]  = irq_m[0];
        w_mip_csr[7]  = irq_m[1];
        w_mip_csr[11] = irq_m[2];
    end

    // combinational read decode
    always_comb begin
        w_rdata  = '0;
        w_rexc   = 1'b0;
        w_cnt    = '0;
        w_cnt_ok = 1'b1;
        case (r_addr[4:0])
            5'd0:    w_cnt = r_mcycle;
            5'd1:    w_cnt_ok = 1'b0;   // no counter lives at index 1 here
            5'd2:    w_cnt = r_minstret;
            default: begin
                for (int i = 0; i < NUM_HPM; i++)
                    if (r_addr[4:0] == 5'(i + 3)) w_cnt = r_hpm[i];
            end
        endcase
        case (r_addr)
            12'hF11, 12'hF12, 12'hF13: w_rdata = '0;
            12'hF14: w_rdata = XLEN'(HART_ID);
            12'h300: w_rdata = w_mstatus;
            12'h301: w_rdata = MISA;
            12'h304: w_rdata = w_mie_csr;
            12'h305: w_rdata = r_mtvec;
            12'h340: w_rdata = r_mscratch;
            12'h341: w_rdata = r_mepc;
            12'h342: w_rdata = r_mcause;
            12'h343: w_rdata = r_mtval;
            12'h344: w_rdata = w_mip_csr;
            default: begin
                if (r_addr[11:5] == 7'h58 && w_cnt_ok)
                    w_rdata = w_cnt[XLEN-1:0];
                else if (XLEN == 32 && r_addr[11:5] == 7'h5C && w_cnt_ok)
                    w_rdata = XLEN'(w_cnt[63:32]);
                else if (r_addr >= 12'h323 && r_addr <= 12'h33F)
                    w_rdata = '0;   // mhpmevent: present, hardwired zero
                else
                    w_rexc = 1'b1;
            end
        endcase
    end

    // architectural state: trap beats mret, mret beats a same-cycle mstatus write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtvec        <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_en       <= '0;
            r_irq          <= 1'b0;
        end else begin
            r_irq <= r_mstatus_mie & |(irq_m & r_mie_en);
            if (w_trap_en) begin
                r_mepc         <= {w_pc[XLEN-1:2], 2'b00};
                r_mcause       <= w_cause;
                r_mtval        <= '0;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (w_we) begin
                    case (w_addr)
                        12'h300: begin
                            r_mstatus_mie  <= w_data[3];
                            r_mstatus_mpie <= w_data[7];
                        end
                        12'h304: r_mie_en   <= {w_data[11], w_data[7], w_data[3]};
                        12'h305: r_mtvec    <= {w_data[XLEN-1:2], 1'b0, w_data[0]};
                        12'h340: r_mscratch <= w_data;
                        12'h341: r_mepc     <= {w_data[XLEN-1:2], 2'b00};
                        12'h342: r_mcause   <= w_data;
                        12'h343: r_mtval    <= w_data;
                        default: ;
                    endcase
                end
                if (w_mret_en) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
            end
        end
    end

    // 64-bit counters: free-running mcycle, minstret and event-driven hpm counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
            r_hpm      <= '0;
        end else begin
            r_mcycle   <= f_cnt_next(r_mcycle, 1'b1, w_we && w_addr == 12'hB00,
                                     (XLEN == 32) && w_we && w_addr == 12'hB80, w_wd64);
            r_minstret <= f_cnt_next(r_minstret, instret, w_we && w_addr == 12'hB02,
                                     (XLEN == 32) && w_we && w_addr == 12'hB82, w_wd64);
            for (int i = 0; i < HPM_N; i++)
                r_hpm[i] <= (i < NUM_HPM)
                    ? f_cnt_next(r_hpm[i], hpm_event[i], w_we && w_addr == 12'(12'hB03 + i),
                                 (XLEN == 32) && w_we && w_addr == 12'(12'hB83 + i), w_wd64)
                    : 64'd0;
        end
    end
endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m (XLEN=32): directed scenarios then random traffic.
// Each cycle the stimulus side pushes the reference model's expected outputs;
// a monitor on the falling edge pops and compares against the DUT.
module tb_csr_file_m;
    localparam int XLEN = 32;
    localparam int NUM_HPM = 4;
    localparam int HART = 3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [11:0] r_addr = '0, w_addr = '0;
    logic [31:0] r_rdata, mtvec, mepc, trap_target;
    logic        r_ro, r_exception, irq_pending;
    logic [31:0] w_data = '0, w_pc = '0, w_cause = '0;
    logic        w_trap = 0, w_valid = 0, mret = 0, instret = 0;
    logic [NUM_HPM-1:0] hpm_event = '0;
    logic [2:0]  irq_m = '0;

    always #5 clk = ~clk;

    csr_file_m #(.XLEN(XLEN), .HART_ID(HART), .MTVEC_RESET(32'h8000_0003), .NUM_HPM(NUM_HPM)) dut (
        .clk(clk), .rst_n(rst_n), .r_addr(r_addr), .r_rdata(r_rdata), .r_ro(r_ro),
        .r_exception(r_exception), .mtvec(mtvec), .mepc(mepc), .w_addr(w_addr),
        .w_data(w_data), .w_pc(w_pc), .w_cause(w_cause), .w_trap(w_trap), .w_valid(w_valid),
        .mret(mret), .instret(instret), .hpm_event(hpm_event), .irq_m(irq_m),
        .irq_pending(irq_pending), .trap_target(trap_target));

    typedef struct {
        logic [11:0] addr;
        logic [31:0] rdata, tt, mtv, mep;
        logic        exc, ro, irq;
    } exp_t;
    exp_t sbq[$];
    int checks = 0, failures = 0;

    // reference model state
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic        m_mie, m_mpie, m_irq;
    logic [2:0]  m_ien;
    logic [63:0] m_cnt[32];
    logic        force_en = 0;
    logic [31:0] force_val = '0;

    logic [11:0] addrs[26] = '{12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h300, 12'h301, 12'h304,
                               12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'h323,
                               12'hB00, 12'hB01, 12'hB02, 12'hB03, 12'hB06, 12'hB07, 12'hB80,
                               12'hB82, 12'hB84, 12'hB9F, 12'h320, 12'h7C0};

    function automatic bit cnt_impl(input int k);
        return k == 0 || k == 2 || (k >= 3 && k < 3 + NUM_HPM);
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [31:0] d, output logic e);
        int k;
        d = '0; e = 1'b0; k = int'(a[4:0]);
        case (a)
            12'hF11, 12'hF12, 12'hF13: d = '0;
            12'hF14: d = HART;
            12'h300: d = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h301: d = 32'h4000_0100;
            12'h304: d = (32'(m_ien[0]) << 3) | (32'(m_ien[1]) << 7) | (32'(m_ien[2]) << 11);
            12'h305: d = m_mtvec;
            12'h340: d = m_mscratch;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h343: d = m_mtval;
            12'h344: d = (32'(irq_m[0]) << 3) | (32'(irq_m[1]) << 7) | (32'(irq_m[2]) << 11);
            default: begin
                if (a >= 12'hB00 && a <= 12'hB1F) begin
                    if (k == 1) e = 1'b1; else if (cnt_impl(k)) d = m_cnt[k][31:0];
                end else if (a >= 12'hB80 && a <= 12'hB9F) begin
                    if (k == 1) e = 1'b1; else if (cnt_impl(k)) d = m_cnt[k][63:32];
                end else if (!(a >= 12'h323 && a <= 12'h33F)) e = 1'b1;
            end
        endcase
    endfunction

    function automatic logic [31:0] model_tt();
        logic [31:0] base;
        base = m_mtvec & ~32'h3;
        if (m_mtvec[0] && w_cause[31]) return base + 4 * (w_cause & 32'h1F);
        return base;
    endfunction

    task automatic model_step();
        logic [63:0] inc;
        if (!rst_n) begin
            m_mtvec = 32'h8000_0000; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_mie = 0; m_mpie = 0; m_irq = 0; m_ien = 0;
            for (int k = 0; k < 32; k++) m_cnt[k] = 0;
            return;
        end
        m_irq = m_mie && ((irq_m & m_ien) != 0);
        for (int k = 0; k < 32; k++) begin
            if (!cnt_impl(k)) continue;
            inc = (k == 0) ? 1 : (k == 2) ? 64'(instret) : 64'(hpm_event[k-3]);
            if (w_valid && !w_trap && w_addr == 12'hB00 + 12'(k))
                m_cnt[k] = {m_cnt[k][63:32], w_data};
            else if (w_valid && !w_trap && w_addr == 12'hB80 + 12'(k))
                m_cnt[k] = {w_data, m_cnt[k][31:0]};
            else
                m_cnt[k] = m_cnt[k] + inc;
        end
        if (w_valid && w_trap) begin
            m_mepc = w_pc & ~32'h3; m_mcause = w_cause; m_mtval = 0;
            m_mpie = m_mie; m_mie = 0;
        end else begin
            if (w_valid) begin
                case (w_addr)
                    12'h300: begin m_mie = w_data[3]; m_mpie = w_data[7]; end
                    12'h304: m_ien = {w_data[11], w_data[7], w_data[3]};
                    12'h305: m_mtvec = w_data & ~32'h2;
                    12'h340: m_mscratch = w_data;
                    12'h341: m_mepc = w_data & ~32'h3;
                    12'h342: m_mcause = w_data;
                    12'h343: m_mtval = w_data;
                    default: ;
                endcase
            end
            if (mret) begin m_mie = m_mpie; m_mpie = 1; end
        end
    endtask

    // push this cycle's expectation, then advance one clock
    task automatic step();
        exp_t e;
        logic [31:0] d;
        logic x;
        if (rst_n) begin
            model_read(r_addr, d, x);
            e.addr = r_addr; e.rdata = force_en ? force_val : d; e.exc = x;
            e.ro = (r_addr[11:10] == 2'b11); e.tt = model_tt(); e.irq = m_irq;
            e.mtv = m_mtvec; e.mep = m_mepc;
            sbq.push_back(e);
        end
        force_en = 0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        w_valid = 0; w_trap = 0; mret = 0; instret = 0; hpm_event = '0;
    endtask

    task automatic rd(input logic [11:0] a, input bit fe = 0, input logic [31:0] fv = 0);
        r_addr = a; force_en = fe; force_val = fv;
        step();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [11:0] ra,
                      input bit fe = 0, input logic [31:0] fv = 0);
        w_valid = 1; w_trap = 0; w_addr = a; w_data = d; r_addr = ra;
        force_en = fe; force_val = fv;
        step();
        w_valid = 0;
    endtask

    task automatic chk(input string nm, input logic [11:0] a, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s addr=%h got=%h expected=%h", nm, a, act, exp);
        end
    endtask

    // monitor: compare DUT outputs against the queued expectation mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("rdata", e.addr, r_rdata, e.rdata);
                chk("exception", e.addr, 32'(r_exception), 32'(e.exc));
                chk("ro", e.addr, 32'(r_ro), 32'(e.ro));
                chk("trap_target", e.addr, trap_target, e.tt);
                chk("irq_pending", e.addr, 32'(irq_pending), 32'(e.irq));
                chk("mtvec", e.addr, mtvec, e.mtv);
                chk("mepc", e.addr, mepc, e.mep);
            end
        end
    end

    initial begin
        // reset while a write is pending: the write must be discarded
        rst_n = 0;
        w_valid = 1; w_addr = 12'h340; w_data = 32'h55;
        repeat (3) step();
        idle(); rst_n = 1;
        rd(12'hB00, 1, 32'd0);
        rd(12'hB00, 1, 32'd1);
        rd(12'h305, 1, 32'h8000_0000);
        rd(12'h340, 1, 32'h0);
        // same-cycle read returns the old value
        wr(12'h340, 32'hDEAD_BEEF, 12'h340, 1, 32'h0);
        rd(12'h340, 1, 32'hDEAD_BEEF);
        wr(12'hF14, 32'd5, 12'hF14, 1, HART);
        rd(12'hF14, 1, HART);
        // vectored trap
        wr(12'h300, 32'h8, 12'h300);
        wr(12'h305, 32'h101, 12'h305, 1, 32'h0000_0100 - 32'h0000_0100 + 32'h8000_0000);
        w_valid = 1; w_trap = 1; w_pc = 32'h2002; w_cause = 32'h8000_0007; r_addr = 12'h300;
        step(); idle();
        w_cause = 32'h8000_0007;
        rd(12'h305, 1, 32'h101);
        rd(12'h341, 1, 32'h2000);
        rd(12'h342, 1, 32'h8000_0007);
        rd(12'h300, 1, 32'h1880);
        mret = 1; rd(12'h300); mret = 0;
        rd(12'h300, 1, 32'h1888);
        // interrupt pending
        wr(12'h304, 32'h80, 12'h304);
        irq_m = 3'b010;
        rd(12'h344, 1, 32'h80);
        rd(12'h344);
        wr(12'h300, 32'h0, 12'h300);
        rd(12'h300); rd(12'h300);
        irq_m = 3'b000;
        // counter halves and carry
        wr(12'hB00, 32'hFFFF_FFFF, 12'hB00);
        rd(12'hB00, 1, 32'hFFFF_FFFF);
        rd(12'hB80, 1, 32'h1);
        rd(12'hB00, 1, 32'h1);
        instret = 1; rd(12'hB02);
        wr(12'hB82, 32'h7, 12'hB02);
        instret = 0;
        rd(12'hB82, 1, 32'h7);
        rd(12'hB02);
        // 64-bit wrap
        wr(12'hB80, 32'hFFFF_FFFF, 12'hB80);
        wr(12'hB00, 32'hFFFF_FFFF, 12'hB00);
        rd(12'hB80, 1, 32'hFFFF_FFFF);
        rd(12'hB80, 1, 32'h0);
        rd(12'hB00, 1, 32'h1);
        // unimplemented and hpm
        rd(12'h7C0, 1, 32'h0);
        hpm_event = 4'b0001;
        rd(12'hB03); rd(12'hB03); rd(12'hB03);
        hpm_event = '0;
        rd(12'hB03, 1, 32'd3);
        rd(12'hB07, 1, 32'd0);
        rd(12'hB87, 1, 32'd0);
        // trap and mret together: trap only
        wr(12'h300, 32'h8, 12'h300);
        w_valid = 1; w_trap = 1; mret = 1; w_pc = 32'h4001; w_cause = 32'h2; r_addr = 12'h300;
        step(); idle();
        rd(12'h300, 1, 32'h1880);
        rd(12'h341, 1, 32'h4000);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            r_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 25)];
            w_valid = $urandom_range(0, 1);
            w_trap  = ($urandom_range(0, 9) == 0);
            w_addr  = addrs[$urandom_range(0, 25)];
            w_data  = $urandom;
            w_pc    = $urandom;
            w_cause = {1'($urandom), 26'd0, 5'($urandom)};
            instret = $urandom_range(0, 1);
            hpm_event = NUM_HPM'($urandom);
            if ($urandom_range(0, 4) == 0) irq_m = 3'($urandom);
            mret = ($urandom_range(0, 19) == 0) && !(w_valid && !w_trap && w_addr == 12'h300);
            step();
        end
        idle();
        rd(12'h300); rd(12'h305);
        @(negedge clk); @(negedge clk);
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
